// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter granting one of 8 requesters, with hold-time limit
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_valid,
    output logic       o_timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t            r_state;
    logic [2:0]        r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        r_gnt;
    logic [2:0]        r_idx;
    logic              r_valid;
    logic              r_timeout;
    logic [2:0]        w_start;
    logic [2:0]        w_win;
    logic              w_release;
    logic              w_expire;

    assign w_start     = r_ptr + 3'd1;
    assign w_release   = i_done || !i_req[r_idx];
    assign w_expire    = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_idx;
    assign o_gnt_valid = r_valid;
    assign o_timeout   = r_timeout;

    // first active request after the last owner; descending scan leaves the nearest one
    always_comb begin
        w_win = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (i_req[w_start + 3'(i)]) w_win = w_start + 3'(i);
    end

    // arbitration FSM with registered grant outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd7;
            r_hold    <= '0;
            r_gnt     <= 8'h00;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == IDLE) begin
            r_timeout <= 1'b0;
            if (|i_req) begin
                r_state <= GRANT;
                r_ptr   <= w_win;
                r_hold  <= HOLD_W'(1);
                r_gnt   <= 8'h01 << w_win;
                r_idx   <= w_win;
                r_valid <= 1'b1;
            end
        end else if (w_release || w_expire) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_gnt     <= 8'h00;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= !w_release;
        end else begin
            r_hold <= (MAX_HOLD == 0) ? r_hold : r_hold + 1'b1;
        end
    end
endmodule
